// File: rtl/capture_ctrl.sv
// Capture sequencer: decodes bus commands, runs the ARMED/POST/DONE capture
// state machine and streams prescaled probe samples into the capture memory.
module capture_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 8,
  parameter int POST  = 192
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_we,
  input  logic             in_we_cr,
  input  logic             in_reset,
  input  logic             in_idle,
  input  logic             in_unidle,
  input  logic [7:0]       in_wdata,
  input  logic [WIDTH-1:0] in_probe,
  output logic             out_mem_we,
  output logic [AW-1:0]    out_mem_addr,
  output logic [WIDTH-1:0] out_mem_data,
  output logic [AW-1:0]    out_trig_addr,
  output logic [1:0]       out_state,
  output logic             out_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int            AWP       = AW + 1;
  localparam logic [AW:0]   POST_LAST = AWP'(POST);

  state_t           state_r;
  logic             done_r;
  logic [7:0]       cr_r;
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    trig_addr_r;
  logic [AW:0]      post_cnt_r;
  logic [6:0]       presc_r;
  logic             prev_valid_r;
  logic             prev_bit_r;

  logic             cmd_reset_s;
  logic             cmd_idle_s;
  logic             cmd_unidle_s;
  logic             cmd_cr_s;
  logic             running_s;
  logic [6:0]       presc_mask_s;
  logic             tick_s;
  logic             cur_bit_s;
  logic             edge_hit_s;
  logic [AW:0]      post_cnt_nx_s;
  logic             unused_rsvd_s;

  // Selects the trigger channel bit; the channel field wraps modulo WIDTH.
  function automatic logic sel_bit(input logic [WIDTH-1:0] v, input logic [2:0] ch);
    int   idx;
    logic b;
    idx = int'(ch) % WIDTH;
    b   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      b = b | (v[i] & (i == idx));
    end
    return b;
  endfunction

  assign cmd_reset_s   = in_we & in_reset;
  assign cmd_idle_s    = in_we & in_idle;
  assign cmd_unidle_s  = in_we & in_unidle;
  assign cmd_cr_s      = in_we & in_we_cr;

  assign running_s     = (state_r == ST_ARMED) || (state_r == ST_POST);
  assign presc_mask_s  = 7'((8'd1 << cr_r[7:5]) - 8'd1);
  assign tick_s        = running_s && (presc_r == presc_mask_s);

  // Edge qualification needs a valid previous tick sample; the first tick after arming only seeds it.
  assign cur_bit_s     = sel_bit(in_probe, cr_r[2:0]);
  assign edge_hit_s    = prev_valid_r &&
                         (cr_r[3] ? (!prev_bit_r && cur_bit_s) : (prev_bit_r && !cur_bit_s));
  assign post_cnt_nx_s = post_cnt_r + AWP'(1);

  assign unused_rsvd_s = cr_r[4];

  assign out_state     = state_r;
  assign out_done      = done_r;
  assign out_trig_addr = trig_addr_r;

  // Command decode, prescaler, trigger detection and capture-memory write generation.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r      <= ST_IDLE;
      done_r       <= 1'b0;
      cr_r         <= 8'h00;
      wptr_r       <= '0;
      trig_addr_r  <= '0;
      post_cnt_r   <= '0;
      presc_r      <= 7'd0;
      prev_valid_r <= 1'b0;
      prev_bit_r   <= 1'b0;
      out_mem_we   <= 1'b0;
      out_mem_addr <= '0;
      out_mem_data <= '0;
    end else begin
      out_mem_we <= 1'b0;
      if (cmd_reset_s) begin
        state_r      <= ST_IDLE;
        done_r       <= 1'b0;
        wptr_r       <= '0;
        trig_addr_r  <= '0;
        post_cnt_r   <= '0;
        prev_valid_r <= 1'b0;
      end else if (cmd_idle_s) begin
        state_r <= ST_IDLE;
        done_r  <= 1'b0;
      end else if (cmd_unidle_s && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
        state_r      <= ST_ARMED;
        done_r       <= 1'b0;
        wptr_r       <= '0;
        post_cnt_r   <= '0;
        presc_r      <= 7'd0;
        prev_valid_r <= 1'b0;
      end else if (cmd_cr_s && (state_r == ST_IDLE)) begin
        cr_r <= in_wdata;
      end else if (running_s) begin
        presc_r <= tick_s ? 7'd0 : (presc_r + 7'd1);
        if (tick_s) begin
          out_mem_we   <= 1'b1;
          out_mem_addr <= wptr_r;
          out_mem_data <= in_probe;
          wptr_r       <= wptr_r + AW'(1);
          if (state_r == ST_ARMED) begin
            prev_bit_r   <= cur_bit_s;
            prev_valid_r <= 1'b1;
            if (edge_hit_s) begin
              trig_addr_r <= wptr_r;
              post_cnt_r  <= AWP'(1);
              if (POST_LAST == AWP'(1)) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_POST;
              end
            end
          end else begin
            post_cnt_r <= post_cnt_nx_s;
            if (post_cnt_nx_s == POST_LAST) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Capture sequencer directly downstream of the MMIO address decoder. It consumes the decoder's control-register write strobe and its reset/idle/unidle command strobes, then runs the sample/trigger state machine. It drives write address, data and enable into the capture memory, and reports state, trigger position and completion back to the bus side.

Parameters:
WIDTH, 8, number of probe channels (sample width)
AW, 8, capture memory address width (depth = 2^AW)
POST, 192, samples stored after and including the trigger sample (1..2^AW)

Ports:
in_clk  input  1  system clock, all logic on rising edge
in_rst_n  input  1  asynchronous active-low reset
in_we  input  1  bus write strobe; qualifies every decoder strobe below
in_we_cr  input  1  decoder: control-register address selected
in_reset  input  1  decoder: reset-command address selected
in_idle  input  1  decoder: idle-command address selected
in_unidle  input  1  decoder: unidle (arm) command address selected
in_wdata  input  8  bus write data
in_probe  input  WIDTH  probe channels, synchronous to in_clk
out_mem_we  output  1  capture memory write enable, one-cycle pulse
out_mem_addr  output  AW  capture memory write address
out_mem_data  output  WIDTH  capture memory write data
out_trig_addr  output  AW  address where the trigger sample was written
out_state  output  2  0=IDLE 1=ARMED 2=POST 3=DONE
out_done  output  1  high while state is DONE

Behaviour:
- Reset (in_rst_n low, async): state IDLE, CR=0x00, wptr=0, post counter=0, prescaler=0, prev-valid=0; all outputs 0.
- Command = decoder strobe AND in_we. Strobes without in_we are ignored.
- CR write (in_we & in_we_cr): CR<=in_wdata, accepted only in IDLE; ignored in other states.
- CR fields: [2:0] trigger channel (modulo WIDTH), [3] edge (1=rising, 0=falling), [4] reserved (reads back, no effect), [7:5] prescale n, giving a sample tick every 2^n clocks.
- Command priority when several are set in one cycle: reset > idle > unidle > CR write.
- reset cmd: any state -> IDLE. Clears wptr, out_trig_addr, post counter, prev-valid. CR is kept.
- idle cmd: any state -> IDLE. Pointers and trigger address are kept, so a DONE capture stays readable.
- unidle cmd: from IDLE or DONE -> ARMED. Clears wptr, post counter, prescaler and prev-valid. Ignored in ARMED and POST.
- Prescaler: runs only in ARMED/POST. Tick when count == 2^n-1, then count restarts at 0. n=0 gives a tick every clock. The first tick falls 2^n clocks after entering ARMED.
- On each tick in ARMED or POST:
  - Sample = in_probe at that edge.
  - Next cycle: out_mem_we=1, out_mem_data=sample, out_mem_addr=wptr. Then wptr<=wptr+1, wrapping mod 2^AW.
- Trigger: on a tick in ARMED with prev-valid=1.
  - Rising: previous bit 0 and current bit 1 on the selected channel. Falling: the inverse.
  - The first tick after arming only loads prev (prev-valid<=1) and cannot trigger, but it is stored.
- On trigger: out_trig_addr<=wptr of that sample, state -> POST, post counter<=1.
- In ARMED the buffer wraps freely, overwriting the oldest samples (pre-trigger history).
- POST: each tick increments the post counter. On the tick that makes the count == POST, the sample is still written and state -> DONE. With POST=1, the trigger tick goes directly to DONE.
- DONE: no ticks, no writes; out_done=1; wptr and out_trig_addr held.
- out_mem_we is never high in IDLE/DONE except for the one pending write from the final tick. That write completes even if the state changed on that cycle.
- A reset or idle command cancels any pending write.
- out_state and out_done are registered and reflect the state after the edge.

Test Plan:
1. Async reset mid-POST (rst_n low between edges) -> all outputs 0 immediately; state 0 after release; CR reads 0x00.
2. CR=0x08 (ch0 rising, n=0), unidle, probe[0]: 0 for 5 clocks then 1 -> trigger sample at addr 5, out_trig_addr=5, exactly POST=192 writes from addr 5 to 196, out_done=1 after write 196.
3. CR=0x40 (n=2, falling ch0), probe[0]=1 then 0 -> writes only every 4th clock; trigger on the first falling tick, not on raw probe edge timing.
4. Armed for 300 ticks with no edge -> wptr wraps 255->0; out_mem_addr sequence 0..255,0..43; state stays 1.
5. Same cycle in_we=1 with in_reset=1 and in_unidle=1 -> IDLE wins; in_unidle=1 with in_we=0 -> no state change; CR write while ARMED -> CR unchanged.
6. idle cmd in DONE -> state 0, out_trig_addr held; then unidle -> ARMED with wptr=0, first tick does not trigger even if an edge is present.
